// File: rtl/param_datapath.sv
// Parametrised CPU datapath: PC, IR, register file, ALU, PVSC flags, req/ack memory FSM.
// Optional DP_MEM_TIMEOUT_EN aborts a memory wait after TIMEOUT cycles and sets mem_err.
module param_datapath #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch,
  input  logic              load,
  input  logic              store,
  input  logic [REG_AW-1:0] rs_a,
  input  logic [REG_AW-1:0] rs_b,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic [3:0]        alu_op,
  input  logic              reg_we,
  input  logic              pvs_write_en,
  input  logic              pc_we,
  input  logic              pc_src,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  inst,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  inst_q, inst_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  regs_q [NREG];
  logic [WIDTH-1:0]  regs_d [NREG];
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [3:0]        flags_q, flags_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  reg_a, reg_b, op_a, op_b;
  logic [WIDTH-1:0]  imm_s, imm_z, pc_inc, res;
  logic [WIDTH:0]    ext;
  logic [3:0]        alu_flags;
  logic              cin, c, v, tmo;

  assign reg_a  = regs_q[rs_a];
  assign reg_b  = regs_q[rs_b];
  assign imm_z  = {{(WIDTH-8){1'b0}}, inst_q[7:0]};
  assign imm_s  = {{(WIDTH-8){inst_q[7]}}, inst_q[7:0]};
  assign pc_inc = pc_q + WIDTH'(1);
  assign cin    = flags_q[0];

  always_comb begin
    op_a = '0;
    unique case (alu_src_a)
      2'd0: op_a = reg_a;
      2'd1: op_a = pc_q;
      2'd2: op_a = '0;
      2'd3: op_a = inst_q;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (alu_src_b)
      2'd0: op_b = reg_b;
      2'd1: op_b = WIDTH'(1);
      2'd2: op_b = imm_s;
      2'd3: op_b = imm_z;
    endcase
  end

  // Arithmetic runs one bit wide so ext[WIDTH] is carry or borrow.
  always_comb begin
    ext = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_op)
      4'd0: begin
        ext = {1'b0, op_a} + {1'b0, op_b};
        res = ext[M:0];
        c   = ext[WIDTH];
        v   = (op_a[M] == op_b[M]) && (res[M] != op_a[M]);
      end
      4'd1: begin
        ext = {1'b0, op_a} - {1'b0, op_b};
        res = ext[M:0];
        c   = ext[WIDTH];
        v   = (op_a[M] != op_b[M]) && (res[M] != op_a[M]);
      end
      4'd2: res = op_a & op_b;
      4'd3: res = op_a | op_b;
      4'd4: res = op_a ^ op_b;
      4'd5: res = ~op_a;
      4'd6: begin
        res = {op_a[M-1:0], 1'b0};
        c   = op_a[M];
      end
      4'd7: begin
        res = {1'b0, op_a[M:1]};
        c   = op_a[0];
      end
      4'd8: res = op_b;
      4'd9: begin
        ext = {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(cin);
        res = ext[M:0];
        c   = ext[WIDTH];
        v   = (op_a[M] == op_b[M]) && (res[M] != op_a[M]);
      end
      4'd10: begin
        ext = {1'b0, op_a} - {1'b0, op_b} - (WIDTH+1)'(cin);
        res = ext[M:0];
        c   = ext[WIDTH];
        v   = (op_a[M] != op_b[M]) && (res[M] != op_a[M]);
      end
      default: res = '0;
    endcase
  end

  assign alu_flags = {~^res, v, res[M], c};

`ifdef DP_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    tmo   = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!mem_ack) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        tmo   = 1'b1;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Commands capture operands before same-cycle strobes update them.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_rd_d = ld_rd_q;
    flags_d = flags_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (reg_we && rd != '0) regs_d[rd] = res;
      if (pvs_write_en) flags_d = alu_flags;
      if (pc_we) pc_d = pc_src ? res : pc_inc;
      if (fetch) begin
        state_d = FETCH;
        addr_d  = pc_q;
      end else if (load) begin
        state_d = LOAD;
        addr_d  = res;
        ld_rd_d = rd;
      end else if (store) begin
        state_d = STORE;
        addr_d  = res;
        wdata_d = reg_b;
      end
    end else if (mem_ack) begin
      state_d = IDLE;
      done_d  = 1'b1;
      if (state_q == FETCH) begin
        inst_d = mem_rdata;
        pc_d   = pc_inc;
      end
      if (state_q == LOAD && ld_rd_q != '0)
        regs_d[ld_rd_q] = mem_rdata;
    end else if (tmo) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_rd_q <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_rd_q <= ld_rd_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == STORE);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign inst      = inst_q;
  assign flags     = flags_q;
  assign done      = done_q;

endmodule
